axi_batch_rd_ctrl: RTL

AXI_BATCH_RD_CTRL -- requirements
Module: axi_batch_rd_ctrl

---
 rtl/axi_pkg.sv | 17 +
 rtl/axi_burst_sizer.sv | 30 +++
 rtl/axi_batch_rd_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the batched AXI read controller.
//   state_t        : controller FSM encodings
//   BOUNDARY_BYTES : AXI bursts must not cross this address boundary
//   BOUNDARY_W     : address bits below the boundary (log2 of BOUNDARY_BYTES)
package axi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam int unsigned BOUNDARY_BYTES = 4096;
  localparam int unsigned BOUNDARY_W     = 12;

endpackage

// File: rtl/axi_burst_sizer.sv
// Combinational burst sizer: picks the largest legal AR burst as the minimum
// of four beat counts.
//   batch_rem : beats left before the current batch ends
//   xfer_rem  : beats left in the whole transfer
//   bound_rem : beats left before the next 4 KB boundary
//   burst_len : chosen burst length in beats (1..MAX_BURST when inputs are non-zero)
module axi_burst_sizer #(
  parameter int CNT_W     = 32,
  parameter int MAX_BURST = 64
) (
  input  logic [CNT_W-1:0] batch_rem,
  input  logic [CNT_W-1:0] xfer_rem,
  input  logic [CNT_W-1:0] bound_rem,
  output logic [8:0]       burst_len
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] min_cnt;

  // NOTE: every variable written here gets a value before any condition, so no latch can be inferred.
  always_comb begin
    min_cnt = MAX_C;
    if (batch_rem < min_cnt) min_cnt = batch_rem;
    if (xfer_rem  < min_cnt) min_cnt = xfer_rem;
    if (bound_rem < min_cnt) min_cnt = bound_rem;
    burst_len = 9'(min_cnt);
  end

endmodule

// File: rtl/axi_batch_rd_ctrl.sv
// Batched AXI read controller. Reads i_size_bytes from i_base_addr in bursts
// and streams each beat to one of NUM_DST destination buffers, indexing beats
// within fixed-size batches. In batch mode it halts after each batch until
// i_resume.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   i_start/i_dst_sel/i_batch_mode : start pulse, destination, halt-per-batch
//   i_base_addr/i_size_bytes       : beat-aligned base address and byte count
//   i_resume                       : continue from a batch halt
//   m_axi_ar* / m_axi_r*           : AXI read address and read data channels
//   i_dst_ready                    : per-destination accept (backpressure)
//   o_wren/o_wraddr/o_wrdata       : one-hot write strobe, beat index, data
//   o_busy/o_done                  : activity and sticky completion
//   o_batch_done/o_batch_idx       : batch-complete pulse and batch counter
//   o_err                          : sticky rlast/beat-count disagreement
module axi_batch_rd_ctrl
  import axi_pkg::*;
#(
  parameter  int AXI_ADDR_WIDTH      = 64,
  parameter  int AXI_DATA_WIDTH      = 512,
  parameter  int AXI_XFER_SIZE_WIDTH = 32,
  parameter  int NUM_DST             = 4,
  parameter  int BATCH_BEATS         = 3072,
  parameter  int BATCH_CNT_WIDTH     = 15,
  parameter  int MAX_BURST           = 64,
  localparam int BEAT_BYTES          = AXI_DATA_WIDTH / 8,
  localparam int DST_W               = (NUM_DST > 1) ? $clog2(NUM_DST) : 1,
  localparam int BADDR_W             = $clog2(BATCH_BEATS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic [DST_W-1:0]               i_dst_sel,
  input  logic                           i_batch_mode,
  input  logic [AXI_ADDR_WIDTH-1:0]      i_base_addr,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_size_bytes,
  input  logic                           i_resume,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                     m_axi_arlen,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic                           m_axi_rlast,
  input  logic [NUM_DST-1:0]             i_dst_ready,
  output logic [NUM_DST-1:0]             o_wren,
  output logic [BADDR_W-1:0]             o_wraddr,
  output logic [AXI_DATA_WIDTH-1:0]      o_wrdata,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_batch_done,
  output logic [BATCH_CNT_WIDTH-1:0]     o_batch_idx,
  output logic                           o_err
);

  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int XW         = AXI_XFER_SIZE_WIDTH;

  state_t                    state;
  logic [DST_W-1:0]          sel_q;
  logic                      mode_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;      // address of the next burst
  logic [XW-1:0]             beats_left;  // beats left in the transfer
  logic [BADDR_W-1:0]        batch_pos;   // beat index within the batch
  logic [8:0]                burst_left;  // beats left in the current burst
  logic                      arvalid_q;

  logic [XW-1:0]           total_beats;
  logic [XW-1:0]           batch_rem;
  logic [XW-1:0]           bound_rem;
  logic [BOUNDARY_W:0]     bound_bytes;
  logic [8:0]              burst_len;
  logic                    ar_fire;
  logic                    r_fire;
  logic                    burst_last;
  logic                    batch_end;
  logic                    xfer_last;

  assign total_beats = i_size_bytes >> BEAT_SHIFT;
  assign batch_rem   = XW'(BATCH_BEATS) - XW'(batch_pos);
  assign bound_bytes = (BOUNDARY_W + 1)'(BOUNDARY_BYTES) - {1'b0, addr_q[BOUNDARY_W-1:0]};
  assign bound_rem   = XW'(bound_bytes >> BEAT_SHIFT);

  // Inputs only change in S_R/S_IDLE, so the length is stable while arvalid is held.
  axi_burst_sizer #(
    .CNT_W     (XW),
    .MAX_BURST (MAX_BURST)
  ) u_sizer (
    .batch_rem (batch_rem),
    .xfer_rem  (beats_left),
    .bound_rem (bound_rem),
    .burst_len (burst_len)
  );

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(burst_len - 9'd1);
  assign m_axi_rready  = (state == S_R) && i_dst_ready[sel_q];
  assign o_busy        = (state != S_IDLE);

  assign ar_fire    = arvalid_q && m_axi_arready;
  assign r_fire     = m_axi_rvalid && m_axi_rready;
  assign burst_last = (burst_left == 9'd1);
  assign batch_end  = (batch_pos == BADDR_W'(BATCH_BEATS - 1));
  assign xfer_last  = (beats_left == XW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sel_q        <= '0;
      mode_q       <= 1'b0;
      addr_q       <= '0;
      beats_left   <= '0;
      batch_pos    <= '0;
      burst_left   <= '0;
      arvalid_q    <= 1'b0;
      o_wren       <= '0;
      o_wraddr     <= '0;
      // NOTE: o_wrdata is an output register, not a storage array, so it is cheap and safe to reset.
      o_wrdata     <= '0;
      o_done       <= 1'b1;
      o_batch_done <= 1'b0;
      o_batch_idx  <= '0;
      o_err        <= 1'b0;
    end else begin
      o_wren       <= '0;
      o_batch_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            sel_q       <= i_dst_sel;
            mode_q      <= i_batch_mode;
            addr_q      <= i_base_addr;
            beats_left  <= total_beats;
            batch_pos   <= '0;
            o_batch_idx <= '0;
            o_err       <= 1'b0;
            if (total_beats == '0) begin
              // Nothing to read: stay idle and report completion immediately.
              o_done <= 1'b1;
            end else begin
              o_done    <= 1'b0;
              arvalid_q <= 1'b1;
              state     <= S_AR;
            end
          end
        end
        S_AR: begin
          if (ar_fire) begin
            arvalid_q  <= 1'b0;
            burst_left <= burst_len;
            addr_q     <= addr_q + (AXI_ADDR_WIDTH'(burst_len) << BEAT_SHIFT);
            state      <= S_R;
          end
        end
        S_R: begin
          if (r_fire) begin
            o_wren     <= NUM_DST'(1) << sel_q;
            o_wraddr   <= batch_pos;
            o_wrdata   <= m_axi_rdata;
            beats_left <= beats_left - 1'b1;
            burst_left <= burst_left - 1'b1;
            // Progress follows our own beat count; a bad rlast is only flagged.
            if (m_axi_rlast != burst_last) o_err <= 1'b1;
            if (batch_end) begin
              batch_pos    <= '0;
              o_batch_idx  <= o_batch_idx + 1'b1;
              o_batch_done <= 1'b1;
            end else begin
              batch_pos <= batch_pos + 1'b1;
            end
            // Bursts never straddle a batch, so a batch end is always a burst end.
            if (burst_last) begin
              if (xfer_last) begin
                o_done <= 1'b1;
                state  <= S_IDLE;
              end else if (batch_end && mode_q) begin
                state <= S_HALT;
              end else begin
                arvalid_q <= 1'b1;
                state     <= S_AR;
              end
            end
          end
        end
        S_HALT: begin
          if (i_resume) begin
            arvalid_q <= 1'b1;
            state     <= S_AR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
